// File: rtl/chip8_step_sequencer_if.sv
// ---------------------------------------------------------------------------
// chip8_step_sequencer_if
// Groups the handshake/bus signals between the step sequencer and the CPU
// core / register file.
//   step_valid   : sequencer -> core, one instruction step is available
//   step_ready   : core -> sequencer, core accepts the step (valid & ready)
//   halt_req     : core -> sequencer, 1-cycle pulse when FX0A is decoded
//   halt_reg     : core -> sequencer, x of FX0A, sampled with halt_req
//   key_wr_valid : sequencer -> register file, write request for Vx
//   key_wr_reg   : sequencer -> register file, x to write
//   key_wr_val   : sequencer -> register file, key index to store
//   key_wr_ready : register file -> sequencer, write accepted
// Modports: master = sequencer side, slave = core / register-file side.
// ---------------------------------------------------------------------------
interface chip8_step_sequencer_if;
    logic       step_valid;
    logic       step_ready;
    logic       halt_req;
    logic [3:0] halt_reg;
    logic       key_wr_valid;
    logic [3:0] key_wr_reg;
    logic [3:0] key_wr_val;
    logic       key_wr_ready;

    modport master (
        output step_valid,
        output key_wr_valid,
        output key_wr_reg,
        output key_wr_val,
        input  step_ready,
        input  halt_req,
        input  halt_reg,
        input  key_wr_ready
    );

    modport slave (
        input  step_valid,
        input  key_wr_valid,
        input  key_wr_reg,
        input  key_wr_val,
        output step_ready,
        output halt_req,
        output halt_reg,
        output key_wr_ready
    );
endinterface

// File: rtl/chip8_step_sequencer.sv
// ---------------------------------------------------------------------------
// chip8_step_sequencer
// Paces a CHIP-8 core. Two phase accumulators turn the core clock into
// instruction-step requests at INSTR_HZ and timer ticks at TIMER_HZ with an
// exact long-run rate. Instruction ticks are queued (up to MAX_PENDING) and
// offered to the core through a valid/ready handshake. The block also owns
// the FX0A "wait for key" halt: it polls the keypad on every instruction tick,
// waits for a press and for the release of that key, then writes the key
// index into Vx.
//
// Ports
//   clk          : core clock
//   rst          : asynchronous reset, active-high
//   enable       : 1 = accumulators advance; 0 = pause (accumulators hold)
//   bus          : step / halt / key-write handshakes (master modport)
//   keys         : live keypad state, bit n = key n down
//   timer_tick   : 1-cycle pulse at TIMER_HZ, runs in every FSM state
//   halted       : FSM is not in RUN
//   overrun      : sticky, an instruction tick was dropped at MAX_PENDING
//   overrun_clr  : clears overrun (a new overrun in the same cycle wins)
// All outputs are registered.
// ---------------------------------------------------------------------------
module chip8_step_sequencer #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int INSTR_HZ    = 500,
    parameter int TIMER_HZ    = 60,
    parameter int MAX_PENDING = 4,
    parameter int ACC_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    chip8_step_sequencer_if.master bus,
    input  logic [15:0]            keys,
    output logic                   timer_tick,
    output logic                   halted,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam int                PEND_W   = $clog2(MAX_PENDING + 1);
    localparam logic [ACC_W-1:0]  CLK_C    = ACC_W'(CLK_HZ);
    localparam logic [ACC_W-1:0]  INSTR_C  = ACC_W'(INSTR_HZ);
    localparam logic [ACC_W-1:0]  TIMER_C  = ACC_W'(TIMER_HZ);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_ZERO = PEND_W'(0);

    typedef enum logic [1:0] {
        S_RUN          = 2'd0,
        S_WAIT_PRESS   = 2'd1,
        S_WAIT_RELEASE = 2'd2,
        S_WRITE        = 2'd3
    } state_t;

    // One accumulator step: returns {tick, next_acc}. The wrap subtracts
    // CLK_HZ instead of resetting to zero so the remainder carries over and
    // the long-run rate is exact. ACC_W is sized so acc + rate never wraps.
    function automatic logic [ACC_W:0] acc_step(
        input logic [ACC_W-1:0] acc,
        input logic [ACC_W-1:0] rate
    );
        logic [ACC_W-1:0] sum;
        sum = acc + rate;
        if (sum >= CLK_C) begin
            return {1'b1, sum - CLK_C};
        end else begin
            return {1'b0, sum};
        end
    endfunction

    // Index of the lowest pressed key; 0 when no key is down.
    function automatic logic [3:0] lowest_set(input logic [15:0] k);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (k[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Accumulators and their tick strobes
    logic [ACC_W-1:0]  instr_acc_q, instr_acc_d;
    logic [ACC_W-1:0]  timer_acc_q, timer_acc_d;
    logic              instr_tick_s;
    logic              timer_tick_s;

    // Control state
    state_t            state_q, state_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic [3:0]        xreg_q, xreg_d;
    logic [3:0]        kreg_q, kreg_d;
    logic              step_hs_s;
    logic              wr_hs_s;
    logic              ovr_set_s;

    // Registered outputs
    logic              overrun_q, overrun_d;
    logic              step_valid_q, step_valid_d;
    logic              halted_q, halted_d;
    logic              key_wr_valid_q, key_wr_valid_d;
    logic [3:0]        key_wr_reg_q, key_wr_reg_d;
    logic [3:0]        key_wr_val_q, key_wr_val_d;
    logic              timer_tick_q, timer_tick_d;

    // Phase accumulators: advance only while enabled, hold otherwise.
    always_comb begin
        instr_acc_d  = instr_acc_q;
        timer_acc_d  = timer_acc_q;
        instr_tick_s = 1'b0;
        timer_tick_s = 1'b0;
        if (enable) begin
            {instr_tick_s, instr_acc_d} = acc_step(instr_acc_q, INSTR_C);
            {timer_tick_s, timer_acc_d} = acc_step(timer_acc_q, TIMER_C);
        end else begin
            instr_acc_d = instr_acc_q;
            timer_acc_d = timer_acc_q;
        end
    end

    // FSM next state, step queue, FX0A key capture and output precompute.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        xreg_d    = xreg_q;
        kreg_d    = kreg_q;
        ovr_set_s = 1'b0;
        step_hs_s = step_valid_q & bus.step_ready;
        wr_hs_s   = key_wr_valid_q & bus.key_wr_ready;

        case (state_q)
            S_RUN: begin
                if (bus.halt_req) begin
                    // A handshake in this cycle is still consumed by the
                    // core; the queue is flushed regardless.
                    xreg_d    = bus.halt_reg;
                    pending_d = PEND_ZERO;
                    state_d   = S_WAIT_PRESS;
                end else if (instr_tick_s && !step_hs_s) begin
                    if (pending_q == PEND_MAX) begin
                        ovr_set_s = 1'b1;
                    end else begin
                        pending_d = pending_q + PEND_ONE;
                    end
                end else if (!instr_tick_s && step_hs_s) begin
                    pending_d = pending_q - PEND_ONE;
                end else begin
                    // tick and handshake together, or neither: no change
                    pending_d = pending_q;
                end
            end
            S_WAIT_PRESS: begin
                if (instr_tick_s && (keys != 16'h0000)) begin
                    kreg_d  = lowest_set(keys);
                    state_d = S_WAIT_RELEASE;
                end else begin
                    state_d = S_WAIT_PRESS;
                end
            end
            S_WAIT_RELEASE: begin
                // Only the captured key matters; other keys are ignored.
                if (instr_tick_s && !keys[kreg_q]) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_WAIT_RELEASE;
                end
            end
            S_WRITE: begin
                if (wr_hs_s) begin
                    state_d   = S_RUN;
                    pending_d = PEND_ZERO;
                end else begin
                    state_d = S_WRITE;
                end
            end
            default: begin
                state_d   = S_RUN;
                pending_d = PEND_ZERO;
            end
        endcase

        // A fresh overrun beats a simultaneous clear.
        overrun_d      = (overrun_q & ~overrun_clr) | ovr_set_s;
        step_valid_d   = (state_d == S_RUN) && (pending_d != PEND_ZERO);
        halted_d       = (state_d != S_RUN);
        key_wr_valid_d = (state_d == S_WRITE);
        key_wr_reg_d   = xreg_d;
        key_wr_val_d   = kreg_d;
        timer_tick_d   = timer_tick_s;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_acc_q    <= {ACC_W{1'b0}};
            timer_acc_q    <= {ACC_W{1'b0}};
            state_q        <= S_RUN;
            pending_q      <= PEND_ZERO;
            xreg_q         <= 4'd0;
            kreg_q         <= 4'd0;
            overrun_q      <= 1'b0;
            step_valid_q   <= 1'b0;
            halted_q       <= 1'b0;
            key_wr_valid_q <= 1'b0;
            key_wr_reg_q   <= 4'd0;
            key_wr_val_q   <= 4'd0;
            timer_tick_q   <= 1'b0;
        end else begin
            instr_acc_q    <= instr_acc_d;
            timer_acc_q    <= timer_acc_d;
            state_q        <= state_d;
            pending_q      <= pending_d;
            xreg_q         <= xreg_d;
            kreg_q         <= kreg_d;
            overrun_q      <= overrun_d;
            step_valid_q   <= step_valid_d;
            halted_q       <= halted_d;
            key_wr_valid_q <= key_wr_valid_d;
            key_wr_reg_q   <= key_wr_reg_d;
            key_wr_val_q   <= key_wr_val_d;
            timer_tick_q   <= timer_tick_d;
        end
    end

    assign bus.step_valid   = step_valid_q;
    assign bus.key_wr_valid = key_wr_valid_q;
    assign bus.key_wr_reg   = key_wr_reg_q;
    assign bus.key_wr_val   = key_wr_val_q;
    assign timer_tick       = timer_tick_q;
    assign halted           = halted_q;
    assign overrun          = overrun_q;

endmodule
